// File: rtl/mem_log_reader.sv
// mem_log_reader: readout stage for the dual-BRAM sample logger.
// Once the logger is full it takes over the logger read port, sweeps every
// address in ascending order, and streams each log word out MSB byte first
// over a valid/ready handshake. o_done pulses when the last byte is accepted.
//
// Ports:
//   clk                  system clock, rising edge
//   i_rst                asynchronous reset, active-low
//   i_start              dump request (honoured only in IDLE)
//   i_mem_full           logger full flag
//   i_data_log_from_mem  logger read data (2*BRAM_DATA_WIDTH bits)
//   o_read_log           read request to logger (level)
//   o_addr_log_to_mem    logger read address
//   o_byte               stream data
//   o_byte_valid         stream valid
//   i_byte_ready         stream ready from consumer
//   o_busy               high in every state except IDLE
//   o_done               one-cycle pulse after the final byte is accepted
module mem_log_reader #(
  parameter int unsigned BRAM_ADDR_WIDTH = 15,
  parameter int unsigned BRAM_DATA_WIDTH = 16,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic                           clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_mem_full,
  input  logic [2*BRAM_DATA_WIDTH-1:0]   i_data_log_from_mem,
  output logic                           o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0]     o_addr_log_to_mem,
  output logic [7:0]                     o_byte,
  output logic                           o_byte_valid,
  input  logic                           i_byte_ready,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int unsigned LW  = 2 * BRAM_DATA_WIDTH;
  localparam int unsigned BPW = LW / 8;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned WCW = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FULL = 3'd1,
    S_SETTLE    = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_CAPTURE   = 3'd4,
    S_SEND      = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  state_e                     state_q, state_d;
  logic                       read_log_q, read_log_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]              shift_q, shift_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [WCW-1:0]             wait_cnt_q, wait_cnt_d;
  logic [BCW-1:0]             byte_cnt_q, byte_cnt_d;

  logic xfer_c, last_byte_c, last_addr_c;

  assign xfer_c      = valid_q & i_byte_ready;
  assign last_byte_c = (byte_cnt_q == BCW'(BPW - 1));
  assign last_addr_c = &addr_q;

  // State register
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (i_start) state_d = S_WAIT_FULL;
      S_WAIT_FULL: if (i_mem_full) state_d = S_SETTLE;
      S_SETTLE:    if (wait_cnt_q == WCW'(SETTLE_CYCLES - 1)) state_d = S_WAIT_DATA;
      S_WAIT_DATA: if (wait_cnt_q == WCW'(RD_LATENCY - 1)) state_d = S_CAPTURE;
      S_CAPTURE:   state_d = S_SEND;
      S_SEND: begin
        if (xfer_c && last_byte_c) begin
          state_d = last_addr_c ? S_DONE : S_WAIT_DATA;
        end
      end
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; every output is taken from a flop
  always_comb begin
    addr_d     = addr_q;
    shift_d    = shift_q;
    valid_d    = valid_q;
    byte_cnt_d = byte_cnt_q;
    wait_cnt_d = '0;
    read_log_d = (state_d == S_SETTLE) || (state_d == S_WAIT_DATA) ||
                 (state_d == S_CAPTURE) || (state_d == S_SEND);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    case (state_q)
      S_WAIT_FULL: begin
        addr_d     = '0;
        byte_cnt_d = '0;
        valid_d    = 1'b0;
      end
      S_SETTLE, S_WAIT_DATA: begin
        // Counter restarts at zero whenever the state is left
        if (state_d == state_q) wait_cnt_d = wait_cnt_q + WCW'(1);
      end
      S_CAPTURE: begin
        shift_d    = i_data_log_from_mem;
        valid_d    = 1'b1;
        byte_cnt_d = '0;
      end
      S_SEND: begin
        if (xfer_c) begin
          if (last_byte_c) begin
            // Address wraps to zero after the final word
            valid_d    = 1'b0;
            byte_cnt_d = '0;
            addr_d     = addr_q + BRAM_ADDR_WIDTH'(1);
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
            shift_d    = shift_q << 8;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      read_log_q <= 1'b0;
      addr_q     <= '0;
      shift_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wait_cnt_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      read_log_q <= read_log_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wait_cnt_q <= wait_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // The current byte is always the top byte of the shift register
  assign o_byte            = shift_q[LW-1 -: 8];
  assign o_read_log        = read_log_q;
  assign o_addr_log_to_mem = addr_q;
  assign o_byte_valid      = valid_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;

endmodule

// File: tb/tb_mem_log_reader.sv
// Bench for mem_log_reader: two instances (RD_LATENCY 1 and 3) share stimulus
// and a behavioural memory; a reference byte list is built from the memory
// contents and compared with the streamed bytes.
module tb_mem_log_reader;

  localparam int unsigned AW  = 3;
  localparam int unsigned DW  = 16;
  localparam int unsigned LW  = 2 * DW;
  localparam int unsigned NW  = 1 << AW;
  localparam int unsigned BPW = LW / 8;
  localparam int unsigned NB  = NW * BPW;

  logic clk;
  logic i_rst;
  logic i_start;
  logic i_mem_full;
  logic i_byte_ready;

  logic [1:0]          rlog_w, valid_w, busy_w, done_w;
  logic [1:0][AW-1:0]  addr_w;
  logic [1:0][7:0]     byte_w;
  logic [1:0][LW-1:0]  data_w;

  logic [LW-1:0] mem [NW];

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus control, written only by the main process
  int rmode     = 0;
  bit spam_en   = 0;
  bit gap_en    = 0;
  bit start_nxt = 0;

  // Monitor state, written only by the monitor process
  logic [7:0] got [2][64];
  int gcnt [2];
  int done_cnt [2];
  int rise_cnt [2];
  int last_x [2];
  bit hold [2];
  logic [7:0] hold_byte [2];
  bit prev_rlog [2];
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [LW-1:0] pipe [3];

    mem_log_reader #(
      .BRAM_ADDR_WIDTH (AW),
      .BRAM_DATA_WIDTH (DW),
      .RD_LATENCY      (LAT),
      .SETTLE_CYCLES   (2)
    ) u_dut (
      .clk                 (clk),
      .i_rst               (i_rst),
      .i_start             (i_start),
      .i_mem_full          (i_mem_full),
      .i_data_log_from_mem (data_w[g]),
      .o_read_log          (rlog_w[g]),
      .o_addr_log_to_mem   (addr_w[g]),
      .o_byte              (byte_w[g]),
      .o_byte_valid        (valid_w[g]),
      .i_byte_ready        (i_byte_ready),
      .o_busy              (busy_w[g]),
      .o_done              (done_w[g])
    );

    // Synchronous-read memory with LAT cycles of read latency
    always @(posedge clk) begin
      pipe[0] <= mem[addr_w[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign data_w[g] = pipe[LAT-1];
  end

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got_v, exp_v, $time);
    end
  endtask

  // Stream monitor: collects accepted bytes, checks hold-stability, gaps, done
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!i_rst) begin
        gcnt[i] = 0; done_cnt[i] = 0; rise_cnt[i] = 0;
        hold[i] = 0; prev_rlog[i] = 0;
      end else begin
        if (i_start && !busy_w[i]) begin
          gcnt[i] = 0; done_cnt[i] = 0; rise_cnt[i] = 0;
        end
        if (hold[i]) begin
          chk("hold_valid", 64'(valid_w[i]), 64'd1);
          chk("hold_byte", 64'(byte_w[i]), 64'(hold_byte[i]));
        end
        if (valid_w[i]) chk("rlog_while_valid", 64'(rlog_w[i]), 64'd1);
        if (done_w[i]) begin
          done_cnt[i]++;
          chk("rlog_at_done", 64'(rlog_w[i]), 64'd0);
        end
        if (rlog_w[i] && !prev_rlog[i]) rise_cnt[i]++;
        prev_rlog[i] = rlog_w[i];
        if (valid_w[i] && i_byte_ready) begin
          if (gap_en && gcnt[i] > 0) begin
            chk(i == 0 ? "gap_lat1" : "gap_lat3", 64'(cyc - last_x[i] - 1),
                (gcnt[i] % BPW == 0) ? 64'((i == 0 ? 1 : 3) + 1) : 64'd0);
          end
          if (gcnt[i] < 64) got[i][gcnt[i]] = byte_w[i];
          gcnt[i]++;
          last_x[i] = cyc;
        end
        hold[i]      = valid_w[i] && !i_byte_ready;
        hold_byte[i] = byte_w[i];
      end
    end
  end

  // Advance one clock and drive inputs just after the edge
  task automatic step();
    @(posedge clk);
    #1;
    i_byte_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (spam_en && gcnt[0] < NB - 4) i_start = 1'($urandom_range(0, 1));
    else                             i_start = start_nxt;
    start_nxt = 0;
  endtask

  function automatic logic [7:0] exp_byte(input int idx);
    logic [LW-1:0] w;
    w = mem[idx / BPW];
    return 8'(w >> (8 * (BPW - 1 - (idx % BPW))));
  endfunction

  task automatic fill_pattern();
    for (int k = 0; k < NW; k++) mem[k] = 32'hA0B0C0D0 + 32'(k);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rlog"},  64'(rlog_w),  64'd0);
    chk({tag, "_addr"},  64'(addr_w),  64'd0);
    chk({tag, "_byte"},  64'(byte_w),  64'd0);
    chk({tag, "_valid"}, 64'(valid_w), 64'd0);
    chk({tag, "_busy"},  64'(busy_w),  64'd0);
    chk({tag, "_done"},  64'(done_w),  64'd0);
  endtask

  task automatic run_dump(input int mode, input bit spam, input int fdelay);
    int k;
    rmode      = mode;
    gap_en     = (mode == 0);
    i_mem_full = (fdelay == 0);
    start_nxt  = 1;
    step();
    step();
    spam_en = spam;
    for (int d = 0; d < fdelay; d++) begin
      chk("no_rlog_before_full",  64'(rlog_w),  64'd0);
      chk("no_valid_before_full", 64'(valid_w), 64'd0);
      chk("busy_wait_full",       64'(busy_w),  64'd3);
      step();
    end
    if (fdelay > 0) begin
      i_mem_full = 1'b1;
      chk("rlog_low_at_full_rise", 64'(rlog_w), 64'd0);
      step();
      chk("rlog_one_after_full", 64'(rlog_w), 64'd3);
    end
    k = 0;
    while (!(done_cnt[0] >= 1 && done_cnt[1] >= 1) && k < 3000) begin
      step();
      k++;
    end
    chk("dump_timeout", 64'(k < 3000), 64'd1);
    spam_en = 0;
    repeat (6) step();
    for (int i = 0; i < 2; i++) begin
      chk("done_once",      64'(done_cnt[i]), 64'd1);
      chk("byte_count",     64'(gcnt[i]),     64'(NB));
      chk("rlog_one_rise",  64'(rise_cnt[i]), 64'd1);
      chk("idle_after",     64'(busy_w[i]),   64'd0);
      for (int b = 0; b < NB; b++) chk("byte_seq", 64'(got[i][b]), 64'(exp_byte(b)));
    end
  endtask

  initial begin
    int k;
    i_rst = 1'b0; i_start = 1'b0; i_mem_full = 1'b0; i_byte_ready = 1'b1;
    fill_pattern();
    #3;
    check_reset_outputs("reset_state");
    step();
    step();
    i_rst = 1'b1;
    step();
    check_reset_outputs("post_reset_idle");

    // Full-rate stream with fixed pattern: checks sequence and gaps
    run_dump(0, 0, 0);
    // Start before full, random backpressure
    run_dump(1, 0, 20);
    // Pure backpressure run
    run_dump(1, 0, 0);
    // Repeated start pulses during the dump, then a second dump afterwards
    run_dump(1, 1, 0);
    for (int w = 0; w < NW; w++) mem[w] = $urandom;
    run_dump(1, 0, 0);
    fill_pattern();

    // Reset after the 10th byte aborts the dump
    rmode = 1; gap_en = 0; i_mem_full = 1'b1; start_nxt = 1;
    step();
    k = 0;
    while (gcnt[0] < 10 && k < 2000) begin
      step();
      k++;
    end
    chk("reach_10th_byte", 64'(k < 2000), 64'd1);
    #2;
    i_rst = 1'b0;
    #1;
    check_reset_outputs("mid_dump_reset");
    step();
    step();
    check_reset_outputs("held_reset");
    i_rst = 1'b1;
    step();
    chk("no_bytes_after_reset", 64'(valid_w), 64'd0);
    run_dump(0, 0, 0);
    chk("restart_first_byte", 64'(got[0][0]), 64'hA0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
